// File: rtl/occ_rom_arbiter.sv
// Round-robin arbiter sharing one combinational-read rom_Occ between the lower-bound (0)
// and upper-bound (1) Occ lookups, with a one-entry registered response slot per requester.
module occ_rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              rready0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              rready1_i,
  output logic              ce_rom_Occ_o,
  output logic [ADDR_W-1:0] addr_rom_Occ_o,
  input  logic [DATA_W-1:0] data_rom_Occ_i
);

  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]             w_req, w_rready, w_free, w_elig, w_gnt;
  logic [NUM_REQ-1:0]             r_rvalid;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_rdata;
  logic                           r_last_gnt;

  assign w_req    = {req1_i, req0_i};
  assign w_rready = {rready1_i, rready0_i};

  // A slot being drained this cycle can take a new response, giving 1/cycle throughput.
  // Eligibility is gated by reset so gnt/ce drop as soon as reset asserts.
  assign w_free = ~r_rvalid | w_rready;
  assign w_elig = w_req & w_free & {NUM_REQ{rst_n}};

  always_comb begin
    w_gnt    = '0;
    w_gnt[0] = w_elig[0] & (~w_elig[1] | r_last_gnt);
    w_gnt[1] = w_elig[1] & (~w_elig[0] | ~r_last_gnt);
  end

  always_comb begin
    ce_rom_Occ_o   = 1'b0;
    addr_rom_Occ_o = '0;
    if (w_gnt[0]) begin
      ce_rom_Occ_o   = 1'b1;
      addr_rom_Occ_o = addr0_i;
    end else if (w_gnt[1]) begin
      ce_rom_Occ_o   = 1'b1;
      addr_rom_Occ_o = addr1_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      for (int n = 0; n < NUM_REQ; n++) begin
        if (w_gnt[n]) begin
          r_rvalid[n] <= 1'b1;
          r_rdata[n]  <= data_rom_Occ_i;
        end else if (r_rvalid[n] && w_rready[n]) begin
          r_rvalid[n] <= 1'b0;
        end
      end
      if (|w_gnt) r_last_gnt <= w_gnt[1];
    end
  end

  assign gnt0_o    = w_gnt[0];
  assign gnt1_o    = w_gnt[1];
  assign rvalid0_o = r_rvalid[0];
  assign rvalid1_o = r_rvalid[1];
  assign rdata0_o  = r_rdata[0];
  assign rdata1_o  = r_rdata[1];

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Directed bench for occ_rom_arbiter; the ROM stand-in returns {16'hC0DE, addr, ~addr}.
module tb_occ_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, rready0, rready1;
  logic [7:0]  addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, ce;
  logic [31:0] rdata0, rdata1, rom_data;
  logic [7:0]  rom_addr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign rom_data = {16'hC0DE, rom_addr, ~rom_addr};

  occ_rom_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0),
    .rvalid0_o(rvalid0), .rdata0_o(rdata0), .rready0_i(rready0),
    .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1),
    .rvalid1_o(rvalid1), .rdata1_o(rdata1), .rready1_i(rready1),
    .ce_rom_Occ_o(ce), .addr_rom_Occ_o(rom_addr), .data_rom_Occ_i(rom_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; rready0 = 0; rready1 = 0; addr0 = '0; addr1 = '0;
    #2;
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_ce", ce, 0);
    cyc; rst_n = 1'b1;

    // single lookup
    cyc; req0 = 1; addr0 = 8'h05; rready0 = 1; #1;
    chk("single_gnt0", gnt0, 1);
    chk("single_gnt1", gnt1, 0);
    chk("single_ce", ce, 1);
    chk("single_addr", rom_addr, 8'h05);
    cyc; req0 = 0; #1;
    chk("single_rvalid0", rvalid0, 1);
    chk("single_rdata0", rdata0, 32'hC0DE05FA);
    chk("single_ce_off", ce, 0);
    cyc; #1;
    chk("single_drained", rvalid0, 0);
    chk("single_rdata_hold", rdata0, 32'hC0DE05FA);

    // contention straight after a reset: 0,1,0,1
    rst_n = 0; #1; rst_n = 1;
    req0 = 1; addr0 = 8'h10; req1 = 1; addr1 = 8'h20; rready1 = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("cont_gnt0", gnt0, (c % 2 == 0));
      chk("cont_gnt1", gnt1, (c % 2 == 1));
      chk("cont_ce", ce, 1);
      chk("cont_addr", rom_addr, (c % 2 == 0) ? 8'h10 : 8'h20);
      if (c % 2 == 1) begin
        chk("cont_rvalid0", rvalid0, 1);
        chk("cont_rdata0", rdata0, 32'hC0DE10EF);
      end else if (c > 0) begin
        chk("cont_rvalid1", rvalid1, 1);
        chk("cont_rdata1", rdata1, 32'hC0DE20DF);
      end
      cyc;
    end

    // backpressure on requester 0
    rready0 = 0; #1;
    chk("bp_first_gnt0", gnt0, 1);
    chk("bp_first_addr", rom_addr, 8'h10);
    cyc;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_gnt0", gnt0, 0);
      chk("bp_gnt1", gnt1, 1);
      chk("bp_addr", rom_addr, 8'h20);
      chk("bp_rvalid0", rvalid0, 1);
      chk("bp_rdata0", rdata0, 32'hC0DE10EF);
      cyc;
    end

    // pause, then drain+refill on slot 0 with slot 1 held full
    req0 = 0; req1 = 0; rready1 = 0; #1;
    chk("pause_ce", ce, 0);
    chk("pause_rvalid0", rvalid0, 1);
    chk("pause_rvalid1", rvalid1, 1);
    cyc;
    req0 = 1; addr0 = 8'h33; rready0 = 1; #1;
    chk("refill_gnt0", gnt0, 1);
    chk("refill_addr", rom_addr, 8'h33);
    chk("refill_old_rdata0", rdata0, 32'hC0DE10EF);
    cyc;
    addr0 = 8'h05; #1;
    chk("refill_rvalid0", rvalid0, 1);
    chk("refill_rdata0", rdata0, 32'hC0DE33CC);
    chk("b2b_gnt0", gnt0, 1);
    chk("held_rvalid1", rvalid1, 1);

    // asynchronous reset mid-cycle
    #1; rst_n = 0; #1;
    chk("arst_rvalid0", rvalid0, 0);
    chk("arst_rvalid1", rvalid1, 0);
    chk("arst_rdata0", rdata0, 0);
    chk("arst_rdata1", rdata1, 0);
    chk("arst_ce", ce, 0);
    chk("arst_gnt0", gnt0, 0);
    #1; rst_n = 1; req1 = 1; addr1 = 8'h20; rready1 = 1; #1;
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1", gnt1, 0);
    cyc;
    req0 = 0; req1 = 0; #1;
    chk("tie_rvalid0", rvalid0, 1);
    chk("tie_rdata0", rdata0, 32'hC0DE05FA);
    cyc;

    // idle
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_ce", ce, 0);
      chk("idle_addr", rom_addr, 0);
      chk("idle_rvalid0", rvalid0, 0);
      chk("idle_rvalid1", rvalid1, 0);
      cyc;
    end
    req0 = 1; addr0 = 8'h10; req1 = 1; addr1 = 8'h20; #1;
    chk("idle_ptr_gnt1", gnt1, 1);
    chk("idle_ptr_gnt0", gnt0, 0);
    chk("idle_ptr_addr", rom_addr, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
